// File: rtl/seq_wave_cmd_scheduler_if.sv
// Host-command and generator-control bundle for seq_wave_cmd_scheduler.
// Latency: none (wires only).
// Backpressure: iCMD_VALID/oCMD_READY handshake on the host side; the generator side has no backpressure.
// Ports: host command (valid/ready/op/channel/time/val), generator status
// (armed/run), error clear, generator control outputs, busy/error/count.
// slave = scheduler view, master = host+generator view.
interface seq_wave_cmd_scheduler_if #(
   parameter int BIT_NUM = 48
);
   logic               iCMD_VALID;
   logic               oCMD_READY;
   logic [2:0]         iCMD_OP;
   logic [7:0]         iCMD_CHANNEL;
   logic [BIT_NUM-1:0] iCMD_TIME;
   logic               iCMD_VAL;
   logic               iGEN_ARMED;
   logic               iGEN_RUN;
   logic               iERR_CLR;
   logic [7:0]         oCTRL_MODE;
   logic               oFLAG_TIME_READY;
   logic               oFLAG_CH_VAL_READY;
   logic [7:0]         oDATA_CHANNEL;
   logic [BIT_NUM-1:0] oDATA_TIME;
   logic               oDATA_CH_VAL;
   logic               oBUSY;
   logic               oERR;
   logic [15:0]        oCMD_COUNT;

   modport slave (
      input  iCMD_VALID, iCMD_OP, iCMD_CHANNEL, iCMD_TIME, iCMD_VAL,
      input  iGEN_ARMED, iGEN_RUN, iERR_CLR,
      output oCMD_READY, oCTRL_MODE, oFLAG_TIME_READY, oFLAG_CH_VAL_READY,
      output oDATA_CHANNEL, oDATA_TIME, oDATA_CH_VAL, oBUSY, oERR, oCMD_COUNT
   );

   modport master (
      output iCMD_VALID, iCMD_OP, iCMD_CHANNEL, iCMD_TIME, iCMD_VAL,
      output iGEN_ARMED, iGEN_RUN, iERR_CLR,
      input  oCMD_READY, oCTRL_MODE, oFLAG_TIME_READY, oFLAG_CH_VAL_READY,
      input  oDATA_CHANNEL, oDATA_TIME, oDATA_CH_VAL, oBUSY, oERR, oCMD_COUNT
   );
endinterface

// File: rtl/seq_wave_cmd_scheduler.sv
// Command scheduler: queues host commands and sequences the wave generator's mode/strobe/data controls.
// Latency: a command pushed into an idle, empty queue shows its mode two cycles later.
// Backpressure: oCMD_READY drops while the 2^FIFO_AW-deep queue is full; the head stalls while the generator is armed/running.
// Ports: iCLK/iNRST (sync active-low) plain; everything else through seq_wave_cmd_scheduler_if.slave.
// Optional macro SEQ_SCHED_CMD_COUNT_EN: enables the 16-bit executed-command counter on oCMD_COUNT.

// Small generic FIFO: push ignored when full, pop ignored when empty.
module seq_wave_cmd_fifo #(
   parameter int W  = 8,
   parameter int AW = 3
) (
   input  logic         clk_i,
   input  logic         nrst_i,
   input  logic         push_vld_i,
   input  logic [W-1:0] push_dat_i,
   output logic         push_rdy_o,
   input  logic         pop_i,
   output logic         head_vld_o,
   output logic [W-1:0] head_dat_o
);
   localparam int            DEPTH    = 1 << AW;
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign push_rdy_o = (cnt_q != FULL_CNT);
   assign head_vld_o = (cnt_q != '0);
   assign head_dat_o = mem_q[rd_ptr_q];
   assign do_push    = push_vld_i && push_rdy_o;
   assign do_pop     = pop_i && head_vld_o;

   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: entries are only read once counted valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end
endmodule

module seq_wave_cmd_scheduler #(
   parameter int         BIT_NUM         = 48,
   parameter int         FIFO_AW         = 3,
   parameter int         STROBE_LEN      = 4,
   parameter int         ARM_TIMEOUT     = 1023,
   parameter logic [7:0] MODE_IDLE       = 8'h00,
   parameter logic [7:0] MODE_ARM        = 8'h01,
   parameter logic [7:0] MODE_SET_PERIOD = 8'h02,
   parameter logic [7:0] MODE_LOAD       = 8'h03,
   parameter logic [7:0] MODE_STOP       = 8'h04
) (
   input  logic                    iCLK,
   input  logic                    iNRST,
   seq_wave_cmd_scheduler_if.slave bus
);
   localparam logic [2:0] OP_NOP        = 3'd0;
   localparam logic [2:0] OP_SET_PERIOD = 3'd1;
   localparam logic [2:0] OP_LOAD_EDGE  = 3'd2;
   localparam logic [2:0] OP_ARM        = 3'd3;
   localparam logic [2:0] OP_STOP       = 3'd4;

   // One counter serves both strobe phases and the arm timeout.
   localparam int               CNT_W      = 16;
   localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(STROBE_LEN - 1);
   localparam logic [CNT_W-1:0] ARM_LAST   = CNT_W'(ARM_TIMEOUT - 1);

   typedef struct packed {
      logic [2:0]         op;
      logic [7:0]         channel;
      logic [BIT_NUM-1:0] tm;
      logic               val;
   } cmd_t;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_T_HI, S_T_LO, S_V_HI, S_V_LO, S_ARM_WAIT, S_GAP
   } state_t;

   cmd_t             push_cmd, head_cmd;
   logic             head_vld, pop, load, err_set, phase_end;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;

   logic [7:0]         mode_q, mode_d;
   logic               tflag_q, tflag_d;
   logic               vflag_q, vflag_d;
   logic [7:0]         dch_q, dch_d;
   logic [BIT_NUM-1:0] dtime_q, dtime_d;
   logic               dval_q, dval_d;
   logic               err_q, err_d;

   assign push_cmd = '{op: bus.iCMD_OP, channel: bus.iCMD_CHANNEL, tm: bus.iCMD_TIME, val: bus.iCMD_VAL};

   seq_wave_cmd_fifo #(.W($bits(cmd_t)), .AW(FIFO_AW)) u_fifo (
      .clk_i      (iCLK),
      .nrst_i     (iNRST),
      .push_vld_i (bus.iCMD_VALID),
      .push_dat_i (push_cmd),
      .push_rdy_o (bus.oCMD_READY),
      .pop_i      (pop),
      .head_vld_o (head_vld),
      .head_dat_o (head_cmd)
   );

   // State register
   always_ff @(posedge iCLK) begin
      if (!iNRST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_NOP;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   // Next state. The head stays in the queue until GAP ends, so the queue
   // keeps reporting busy and a full queue stays full for the whole command.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      op_d      = op_q;
      pop       = 1'b0;
      load      = 1'b0;
      err_set   = 1'b0;
      phase_end = (cnt_q == PHASE_LAST);
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (head_vld) begin
               case (head_cmd.op)
                  OP_NOP: pop = 1'b1;
                  OP_SET_PERIOD, OP_LOAD_EDGE: begin
                     // Loading while armed/running would corrupt the sequence.
                     if (!bus.iGEN_ARMED && !bus.iGEN_RUN) load = 1'b1;
                  end
                  OP_ARM: begin
                     if (!bus.iGEN_RUN) begin
                        if (bus.iGEN_ARMED) pop  = 1'b1;
                        else                load = 1'b1;
                     end
                  end
                  OP_STOP: load = 1'b1;
                  default: begin
                     pop     = 1'b1;
                     err_set = 1'b1;
                  end
               endcase
               if (load) begin
                  state_d = S_SETUP;
                  op_d    = head_cmd.op;
               end
            end
         end
         S_SETUP: begin
            cnt_d = '0;
            if (op_q == OP_ARM)       state_d = S_ARM_WAIT;
            else if (op_q == OP_STOP) state_d = S_GAP;
            else                      state_d = S_T_HI;
         end
         S_T_HI: if (phase_end) begin
            cnt_d   = '0;
            state_d = S_T_LO;
         end
         S_T_LO: if (phase_end) begin
            cnt_d   = '0;
            state_d = (op_q == OP_LOAD_EDGE) ? S_V_HI : S_GAP;
         end
         S_V_HI: if (phase_end) begin
            cnt_d   = '0;
            state_d = S_V_LO;
         end
         S_V_LO: if (phase_end) begin
            cnt_d   = '0;
            state_d = S_GAP;
         end
         S_ARM_WAIT: begin
            if (bus.iGEN_ARMED) begin
               cnt_d   = '0;
               state_d = S_GAP;
            end else if (cnt_q == ARM_LAST) begin
               cnt_d   = '0;
               err_set = 1'b1;
               state_d = S_GAP;
            end
         end
         S_GAP: if (phase_end) begin
            pop     = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: decoded from the current state and registered, so they trail
   // the state by one cycle while the data buses settle a cycle earlier.
   always_comb begin
      mode_d  = MODE_IDLE;
      tflag_d = (state_q == S_T_HI);
      vflag_d = (state_q == S_V_HI);
      if (state_q != S_IDLE && state_q != S_GAP) begin
         case (op_q)
            OP_SET_PERIOD: mode_d = MODE_SET_PERIOD;
            OP_LOAD_EDGE:  mode_d = MODE_LOAD;
            OP_ARM:        mode_d = MODE_ARM;
            OP_STOP:       mode_d = MODE_STOP;
            default:       mode_d = MODE_IDLE;
         endcase
      end
      dch_d   = load ? head_cmd.channel : dch_q;
      dtime_d = load ? head_cmd.tm      : dtime_q;
      dval_d  = load ? head_cmd.val     : dval_q;
      // A new error in the same cycle as a clear must survive.
      if (err_set)          err_d = 1'b1;
      else if (bus.iERR_CLR) err_d = 1'b0;
      else                  err_d = err_q;
   end

   always_ff @(posedge iCLK) begin
      if (!iNRST) begin
         mode_q  <= MODE_IDLE;
         tflag_q <= 1'b0;
         vflag_q <= 1'b0;
         dch_q   <= '0;
         dtime_q <= '0;
         dval_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         tflag_q <= tflag_d;
         vflag_q <= vflag_d;
         dch_q   <= dch_d;
         dtime_q <= dtime_d;
         dval_q  <= dval_d;
         err_q   <= err_d;
      end
   end

   assign bus.oCTRL_MODE         = mode_q;
   assign bus.oFLAG_TIME_READY   = tflag_q;
   assign bus.oFLAG_CH_VAL_READY = vflag_q;
   assign bus.oDATA_CHANNEL      = dch_q;
   assign bus.oDATA_TIME         = dtime_q;
   assign bus.oDATA_CH_VAL       = dval_q;
   assign bus.oERR               = err_q;
   assign bus.oBUSY              = (state_q != S_IDLE) || head_vld;

`ifdef SEQ_SCHED_CMD_COUNT_EN
   logic [15:0] cmd_count_q, cmd_count_d;

   // Counts every pop, NOP and illegal included; wraps naturally.
   assign cmd_count_d = pop ? cmd_count_q + 16'd1 : cmd_count_q;

   always_ff @(posedge iCLK) begin
      if (!iNRST) cmd_count_q <= '0;
      else        cmd_count_q <= cmd_count_d;
   end

   assign bus.oCMD_COUNT = cmd_count_q;
`else
   assign bus.oCMD_COUNT = 16'd0;
`endif
endmodule

// File: tb/tb_seq_wave_cmd_scheduler.sv
module tb_seq_wave_cmd_scheduler;
   localparam int BIT_NUM = 48;

   logic iCLK = 1'b0;
   logic iNRST;

   seq_wave_cmd_scheduler_if #(.BIT_NUM(BIT_NUM)) bus ();

   seq_wave_cmd_scheduler #(.BIT_NUM(BIT_NUM)) dut (
      .iCLK  (iCLK),
      .iNRST (iNRST),
      .bus   (bus)
   );

   always #5 iCLK = ~iCLK;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_count = 0;

   typedef struct {
      logic [2:0]  op;
      logic [7:0]  ch;
      logic [47:0] tm;
      logic        val;
      logic [7:0]  mode;
      int          mode_cyc;
      int          lat;
      int          tcyc;
      int          vcyc;
      int          busy;
      bit          err;
      bit          chk_data;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [63:0] count_exp();
`ifdef SEQ_SCHED_CMD_COUNT_EN
      return 64'(exp_count & 16'hFFFF);
`else
      return 64'd0;
`endif
   endfunction

   // Called at a negedge; the push happens on the following posedge and the
   // task returns at the negedge right after it.
   task automatic push(input logic [2:0] op, input logic [7:0] ch, input logic [47:0] tm, input logic val);
      bus.iCMD_VALID   = 1'b1;
      bus.iCMD_OP      = op;
      bus.iCMD_CHANNEL = ch;
      bus.iCMD_TIME    = tm;
      bus.iCMD_VAL     = val;
      @(negedge iCLK);
      bus.iCMD_VALID   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int mcyc, lat, tc, vc, bc, bad_mode, bad_data, bad, acc, stop_cyc;
      bit found;

      // op, ch, time, val, mode, mode cycles, latency, tflag, vflag, busy, err, data check
      vecs[0] = '{3'd1, 8'd0,   48'd1000,            1'b0, 8'h02, 9,  2,  4, 0, 14, 1'b0, 1'b1};
      vecs[1] = '{3'd2, 8'd5,   48'd77,              1'b1, 8'h03, 17, 2,  4, 4, 22, 1'b0, 1'b1};
      vecs[2] = '{3'd4, 8'd9,   48'd12,              1'b1, 8'h04, 1,  2,  0, 0, 6,  1'b0, 1'b1};
      vecs[3] = '{3'd0, 8'd1,   48'd1,               1'b1, 8'h00, 0,  -1, 0, 0, 1,  1'b0, 1'b0};
      vecs[4] = '{3'd6, 8'd2,   48'd2,               1'b0, 8'h00, 0,  -1, 0, 0, 1,  1'b1, 1'b0};
      vecs[5] = '{3'd1, 8'd0,   48'hFFFF_FFFF_FFFF,  1'b0, 8'h02, 9,  2,  4, 0, 14, 1'b0, 1'b1};
      vecs[6] = '{3'd2, 8'hFF,  48'd0,               1'b0, 8'h03, 17, 2,  4, 4, 22, 1'b0, 1'b1};
      vecs[7] = '{3'd5, 8'd3,   48'd3,               1'b1, 8'h00, 0,  -1, 0, 0, 1,  1'b1, 1'b0};

      bus.iCMD_VALID = 1'b0; bus.iCMD_OP = 3'd0; bus.iCMD_CHANNEL = 8'd0;
      bus.iCMD_TIME = '0; bus.iCMD_VAL = 1'b0;
      bus.iGEN_ARMED = 1'b0; bus.iGEN_RUN = 1'b0; bus.iERR_CLR = 1'b0;
      iNRST = 1'b0;
      repeat (3) @(negedge iCLK);
      iNRST = 1'b1;
      @(negedge iCLK);

      check("rst_mode",  64'(bus.oCTRL_MODE), 64'h00);
      check("rst_flags", 64'({bus.oFLAG_TIME_READY, bus.oFLAG_CH_VAL_READY}), 64'd0);
      check("rst_data",  64'({bus.oDATA_CHANNEL, bus.oDATA_CH_VAL}) | 64'(bus.oDATA_TIME), 64'd0);
      check("rst_err",   64'(bus.oERR), 64'd0);
      check("rst_busy",  64'(bus.oBUSY), 64'd0);
      check("rst_ready", 64'(bus.oCMD_READY), 64'd1);
      check("rst_count", 64'(bus.oCMD_COUNT), 64'd0);

      // Table-driven single commands, generator idle.
      for (int i = 0; i < 8; i++) begin
         mcyc = 0; lat = -1; tc = 0; vc = 0; bc = 0; bad_mode = 0; bad_data = 0;
         push(vecs[i].op, vecs[i].ch, vecs[i].tm, vecs[i].val);
         for (int s = 0; s < 40; s++) begin
            if (bus.oCTRL_MODE != 8'h00) begin
               mcyc++;
               if (lat < 0) lat = s;
               if (bus.oCTRL_MODE != vecs[i].mode) bad_mode++;
            end
            if (bus.oFLAG_TIME_READY) tc++;
            if (bus.oFLAG_CH_VAL_READY) vc++;
            if (bus.oBUSY) bc++;
            if (vecs[i].chk_data && (bus.oFLAG_TIME_READY || bus.oFLAG_CH_VAL_READY) &&
                (bus.oDATA_TIME != vecs[i].tm || bus.oDATA_CHANNEL != vecs[i].ch ||
                 bus.oDATA_CH_VAL != vecs[i].val)) bad_data++;
            @(negedge iCLK);
         end
         exp_count++;
         check($sformatf("v%0d_mode_cycles", i), 64'(mcyc), 64'(vecs[i].mode_cyc));
         check($sformatf("v%0d_latency", i),     64'(lat),  64'(vecs[i].lat));
         check($sformatf("v%0d_mode_value", i),  64'(bad_mode), 64'd0);
         check($sformatf("v%0d_time_flag", i),   64'(tc), 64'(vecs[i].tcyc));
         check($sformatf("v%0d_chval_flag", i),  64'(vc), 64'(vecs[i].vcyc));
         check($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'(vecs[i].busy));
         check($sformatf("v%0d_err", i),         64'(bus.oERR), 64'(vecs[i].err));
         check($sformatf("v%0d_count", i),       64'(bus.oCMD_COUNT), count_exp());
         if (vecs[i].chk_data) begin
            check($sformatf("v%0d_data_stable", i), 64'(bad_data), 64'd0);
            check($sformatf("v%0d_data_time", i),   64'(bus.oDATA_TIME), 64'(vecs[i].tm));
            check($sformatf("v%0d_data_ch", i),     64'({bus.oDATA_CHANNEL, bus.oDATA_CH_VAL}),
                  64'({vecs[i].ch, vecs[i].val}));
         end
         if (vecs[i].err) begin
            bus.iERR_CLR = 1'b1;
            @(negedge iCLK);
            bus.iERR_CLR = 1'b0;
            check($sformatf("v%0d_err_clr", i), 64'(bus.oERR), 64'd0);
         end
      end

      // ARM: generator reports armed 10 cycles into the wait.
      push(3'd3, 8'd0, 48'd0, 1'b0);
      found = 1'b0;
      for (int s = 0; s < 10 && !found; s++) begin
         if (bus.oCTRL_MODE == 8'h01) found = 1'b1;
         else @(negedge iCLK);
      end
      check("arm_mode_seen", 64'(found), 64'd1);
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge iCLK);
         if (bus.oCTRL_MODE != 8'h01) bad++;
      end
      check("arm_hold", 64'(bad), 64'd0);
      bus.iGEN_ARMED = 1'b1;
      @(negedge iCLK);
      @(negedge iCLK);
      check("arm_release_mode", 64'(bus.oCTRL_MODE), 64'h00);
      found = 1'b0;
      for (int s = 0; s < 10 && !found; s++) begin
         if (!bus.oBUSY) found = 1'b1;
         else @(negedge iCLK);
      end
      check("arm_done", 64'(found), 64'd1);
      check("arm_no_err", 64'(bus.oERR), 64'd0);
      exp_count++;

      // ARM while already armed: popped without any output activity.
      push(3'd3, 8'd0, 48'd0, 1'b0);
      mcyc = 0; bc = 0;
      for (int s = 0; s < 10; s++) begin
         if (bus.oCTRL_MODE != 8'h00) mcyc++;
         if (bus.oBUSY) bc++;
         @(negedge iCLK);
      end
      exp_count++;
      check("arm_noop_mode", 64'(mcyc), 64'd0);
      check("arm_noop_busy", 64'(bc), 64'd1);
      bus.iGEN_ARMED = 1'b0;

      // ARM timeout, with a clear landing on the same edge as the error.
      push(3'd3, 8'd0, 48'd0, 1'b0);
      found = 1'b0;
      for (int s = 0; s < 10 && !found; s++) begin
         if (bus.oCTRL_MODE == 8'h01) found = 1'b1;
         else @(negedge iCLK);
      end
      check("tmo_mode_seen", 64'(found), 64'd1);
      repeat (1022) @(negedge iCLK);
      check("tmo_err_before", 64'(bus.oERR), 64'd0);
      bus.iERR_CLR = 1'b1;
      @(negedge iCLK);
      bus.iERR_CLR = 1'b0;
      check("tmo_err_set_wins", 64'(bus.oERR), 64'd1);
      bus.iERR_CLR = 1'b1;
      @(negedge iCLK);
      bus.iERR_CLR = 1'b0;
      check("tmo_err_clr", 64'(bus.oERR), 64'd0);
      found = 1'b0;
      for (int s = 0; s < 10 && !found; s++) begin
         if (!bus.oBUSY) found = 1'b1;
         else @(negedge iCLK);
      end
      check("tmo_done", 64'(found), 64'd1);
      exp_count++;

      // Running generator stalls LOAD_EDGE (and the STOP queued behind it).
      bus.iGEN_RUN = 1'b1;
      push(3'd2, 8'd9, 48'd500, 1'b1);
      push(3'd4, 8'd0, 48'd0, 1'b0);
      mcyc = 0; tc = 0; bc = 0;
      for (int s = 0; s < 20; s++) begin
         if (bus.oCTRL_MODE != 8'h00) mcyc++;
         if (bus.oFLAG_TIME_READY || bus.oFLAG_CH_VAL_READY) tc++;
         if (bus.oBUSY) bc++;
         @(negedge iCLK);
      end
      check("stall_mode", 64'(mcyc), 64'd0);
      check("stall_flags", 64'(tc), 64'd0);
      check("stall_busy", 64'(bc), 64'd20);
      bus.iGEN_RUN = 1'b0;
      tc = 0; vc = 0; stop_cyc = 0;
      for (int s = 0; s < 80; s++) begin
         if (bus.oFLAG_TIME_READY) tc++;
         if (bus.oFLAG_CH_VAL_READY) vc++;
         if (bus.oCTRL_MODE == 8'h04) stop_cyc++;
         @(negedge iCLK);
      end
      exp_count += 2;
      check("unstall_tflag", 64'(tc), 64'd4);
      check("unstall_vflag", 64'(vc), 64'd4);
      check("unstall_stop", 64'(stop_cyc), 64'd1);
      check("unstall_idle", 64'(bus.oBUSY), 64'd0);
      check("unstall_count", 64'(bus.oCMD_COUNT), count_exp());

      // Fill the queue while stalled: 9 offered, 8 accepted.
      bus.iGEN_RUN = 1'b1;
      acc = 0;
      bus.iCMD_OP = 3'd1; bus.iCMD_TIME = 48'd10; bus.iCMD_CHANNEL = 8'd0; bus.iCMD_VAL = 1'b0;
      bus.iCMD_VALID = 1'b1;
      for (int k = 0; k < 9; k++) begin
         if (bus.oCMD_READY) acc++;
         @(negedge iCLK);
      end
      bus.iCMD_VALID = 1'b0;
      check("fill_accepted", 64'(acc), 64'd8);
      check("fill_ready_low", 64'(bus.oCMD_READY), 64'd0);
      bus.iGEN_RUN = 1'b0;
      found = 1'b0;
      for (int s = 0; s < 200 && !found; s++) begin
         if (!bus.oBUSY) found = 1'b1;
         else @(negedge iCLK);
      end
      exp_count += 8;
      check("fill_drained", 64'(found), 64'd1);
      check("fill_ready_back", 64'(bus.oCMD_READY), 64'd1);
      check("fill_count", 64'(bus.oCMD_COUNT), count_exp());

      // Reset in the middle of a time strobe with another command queued.
      push(3'd1, 8'd0, 48'd33, 1'b0);
      push(3'd1, 8'd0, 48'd44, 1'b0);
      found = 1'b0;
      for (int s = 0; s < 12 && !found; s++) begin
         if (bus.oFLAG_TIME_READY) found = 1'b1;
         else @(negedge iCLK);
      end
      check("rst2_in_thi", 64'(found), 64'd1);
      iNRST = 1'b0;
      @(negedge iCLK);
      check("rst2_flags", 64'({bus.oFLAG_TIME_READY, bus.oFLAG_CH_VAL_READY}), 64'd0);
      check("rst2_mode", 64'(bus.oCTRL_MODE), 64'h00);
      check("rst2_fifo_empty", 64'({bus.oBUSY, bus.oCMD_READY}), 64'b01);
      check("rst2_count", 64'(bus.oCMD_COUNT), 64'd0);
      check("rst2_data", 64'(bus.oDATA_TIME), 64'd0);
      iNRST = 1'b1;
      exp_count = 0;
      @(negedge iCLK);
      push(3'd0, 8'd0, 48'd0, 1'b0);
      @(negedge iCLK);
      exp_count++;
      check("rst2_after_nop_idle", 64'(bus.oBUSY), 64'd0);
      check("rst2_after_nop_count", 64'(bus.oCMD_COUNT), count_exp());

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
